// File: rtl/decode_sequencer.sv
// decode_sequencer: runs a program as a series of decoder blocks, then drains the executer.
// Defining SEQ_WATCHDOG_EN adds a WAIT_DEC timeout (WDOG_CYCLES) that raises a sticky error.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

module decode_sequencer #(
  parameter logic [`MEM_ADDR_WIDTH-1:0] START_ADDR  = '0,
  parameter int unsigned                WDOG_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [`MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic                       start_addr_vld,
  input  logic                       halt,
  output logic                       dec_do_it,
  output logic [`MEM_ADDR_WIDTH-1:0] dec_addr,
  input  logic                       dec_done,
  input  logic                       dec_stop,
  input  logic [`MEM_ADDR_WIDTH-1:0] dec_addr_out,
  output logic                       exec_do_it,
  output logic                       exec_stop,
  input  logic                       exec_done,
  output logic                       busy,
  output logic                       finished,
  output logic                       error,
  output logic [15:0]                block_cnt
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DEC, GAP, DRAIN, DONE} state_t;

  state_t                     state_q;
  logic                       dec_done_q;
  logic                       dec_do_it_q;
  logic                       exec_do_it_q;
  logic                       exec_stop_q;
  logic                       busy_q;
  logic                       finished_q;
  logic [`MEM_ADDR_WIDTH-1:0] dec_addr_q;
  logic [15:0]                block_cnt_q;
  logic                       dec_done_rise;

  // A done level held over several cycles must count as a single block.
  assign dec_done_rise = dec_done & ~dec_done_q;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_q;
  logic              error_q;
  logic              wdog_expired;

  assign wdog_expired = (32'(wdog_q) >= WDOG_CYCLES - 1);
  assign error        = error_q;
`else
  assign error = (WDOG_CYCLES == 0) & 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dec_done_q   <= 1'b0;
      dec_do_it_q  <= 1'b0;
      exec_do_it_q <= 1'b0;
      exec_stop_q  <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      dec_addr_q   <= START_ADDR;
      block_cnt_q  <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      dec_done_q <= dec_done;
      finished_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= ISSUE;
            dec_addr_q   <= start_addr_vld ? start_addr : START_ADDR;
            block_cnt_q  <= '0;
            dec_do_it_q  <= 1'b1;
            exec_do_it_q <= 1'b1;
            exec_stop_q  <= 1'b0;
            busy_q       <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
            error_q      <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state_q <= WAIT_DEC;
`ifdef SEQ_WATCHDOG_EN
          wdog_q  <= '0;
`endif
        end
        WAIT_DEC: begin
          if (dec_done_rise) begin
            dec_addr_q  <= dec_addr_out;
            block_cnt_q <= block_cnt_q + 16'd1;
            dec_do_it_q <= 1'b0;
            if (dec_stop || halt) begin
              state_q     <= DRAIN;
              exec_stop_q <= halt;
            end else begin
              state_q <= GAP;
            end
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wdog_expired) begin
            state_q     <= DRAIN;
            dec_do_it_q <= 1'b0;
            exec_stop_q <= 1'b1;
            error_q     <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        GAP: begin
          if (halt) begin
            state_q     <= DRAIN;
            exec_stop_q <= 1'b1;
          end else begin
            state_q     <= ISSUE;
            dec_do_it_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (exec_done) begin
            state_q      <= DONE;
            finished_q   <= 1'b1;
            exec_do_it_q <= 1'b0;
            exec_stop_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_do_it  = dec_do_it_q;
  assign dec_addr   = dec_addr_q;
  assign exec_do_it = exec_do_it_q;
  assign exec_stop  = exec_stop_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign block_cnt  = block_cnt_q;

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 0, giving the fetch address used when start_addr_vld is low.
REQ-002 The block SHALL have parameter WDOG_CYCLES, default 1024, giving the decode-timeout limit in clk cycles.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  single-cycle request to begin a run; ignored unless the block is idle.
REQ-006 Port start_addr / start_addr_vld  in  `MEM_ADDR_WIDTH / 1  first fetch address and its select.
REQ-007 Port halt  in  1  external stop request; level-sensitive.
REQ-008 Port dec_do_it / dec_addr  out  1 / `MEM_ADDR_WIDTH  decoder enable and fetch address.
REQ-009 Port dec_done / dec_stop / dec_addr_out  in  1 / 1 / `MEM_ADDR_WIDTH  decoder block-complete, end-of-program flag and next address.
REQ-010 Port exec_do_it / exec_stop  out  1 / 1  executer enable and stop.
REQ-011 Port exec_done  in  1  executer has drained its FIFO.
REQ-012 Port busy / finished / error  out  1 / 1 / 1  run in progress, one-cycle end-of-run pulse, sticky timeout flag.
REQ-013 Port block_cnt  out  16  number of decoded blocks in the current run.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT_DEC, GAP, DRAIN and DONE.
REQ-015 IDLE: on start, load dec_addr with start_addr if start_addr_vld is high, otherwise with START_ADDR; clear block_cnt and error; go to ISSUE.
REQ-016 dec_do_it SHALL be 1 exactly in ISSUE and WAIT_DEC, and dec_addr SHALL be stable while dec_do_it is 1.
REQ-017 ISSUE SHALL last one cycle and then go to WAIT_DEC.
REQ-018 dec_done SHALL be registered and acted on only at its rising edge, so a level held high over several cycles counts once.
REQ-019 On a dec_done rising edge in WAIT_DEC: latch dec_addr_out into dec_addr and increment block_cnt (mod 2^16, wraps silently).
REQ-020 In the same cycle as REQ-019: if dec_stop or halt is 1, go to DRAIN; otherwise go to GAP.
REQ-021 GAP SHALL hold dec_do_it at 0 for exactly one cycle and then go to ISSUE; if halt is 1 during GAP, go to DRAIN instead.
REQ-022 exec_do_it SHALL rise on the first ISSUE of a run and stay 1 until the DONE state.
REQ-023 exec_stop SHALL be 1 in DRAIN only when the run was entered via halt, not when it was entered via dec_stop.
REQ-024 DRAIN: dec_do_it is 0; on exec_done = 1, go to DONE.
REQ-025 DONE SHALL last one cycle with finished = 1 and exec_do_it = 0, then go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start outside IDLE SHALL be ignored, with no state change.
REQ-028 When dec_done rises and halt is 1 in the same cycle, the address is still latched and counted, then the FSM goes to DRAIN.
REQ-029 A dec_done rising edge outside WAIT_DEC SHALL be ignored.

Reset
REQ-030 While reset = 0, the block SHALL be in IDLE with dec_do_it=0, exec_do_it=0, exec_stop=0, busy=0, finished=0, error=0, block_cnt=0 and dec_addr=START_ADDR.
REQ-031 Reset SHALL take effect immediately, including mid-run; after release the block waits in IDLE for start.

Configuration
REQ-032 With macro SEQ_WATCHDOG_EN defined, a counter SHALL count cycles spent in WAIT_DEC.
REQ-033 With SEQ_WATCHDOG_EN defined and the count reaching WDOG_CYCLES, the FSM SHALL set error=1 and assert exec_stop.
REQ-034 After the timeout of REQ-033, the FSM SHALL go to DRAIN; error stays set until the next accepted start or reset.
REQ-035 Without SEQ_WATCHDOG_EN, error SHALL be tied to 0, no counter is built, and WAIT_DEC waits indefinitely.

Verification
REQ-036 Scenario: start with start_addr_vld=0; decoder returns dec_addr_out 8, 16, 24 and dec_stop on the 3rd done -> dec_addr goes 0,8,16,24; block_cnt=3; a one-cycle dec_do_it gap between blocks; finished pulses after exec_done.
REQ-037 Scenario: halt raised during the 2nd WAIT_DEC -> 2nd block is counted; exec_stop=1 in DRAIN; no 3rd ISSUE.
REQ-038 Scenario: dec_done held high for 5 cycles -> block_cnt increments by exactly 1.
REQ-039 Scenario: start pulsed while busy=1 -> no effect; dec_addr and block_cnt unchanged.
REQ-040 Scenario: reset driven low mid-WAIT_DEC, with no clk edge -> all outputs at reset values immediately.
REQ-041 Scenario (SEQ_WATCHDOG_EN, WDOG_CYCLES=16): dec_done never asserted -> error=1 after 16 WAIT_DEC cycles; exec_stop=1; finished after exec_done.
